simple_bram: RTL and testbench

- Row-buffer memory for a sliding-window (convolution) image pipeline.
- Holds KERNEL_SIZE-1 image rows, each IMAGE_WIDTH pixels deep, as independent BRAM-style banks.
- Writes are serial: one pixel per cycle at a flat address. A read fetches the same column from every row buffer in one access, giving the vertical pixel column the window needs.

---
 rtl/simple_bram.sv | 95 +++++++++
 tb/tb_simple_bram.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/simple_bram.sv
// Row-buffer memory for a sliding-window image pipeline.
// Holds RB_COUNT independent row banks of IMAGE_WIDTH pixels each. Writes land one pixel per
// cycle at a flat address. A read returns the same column from every bank in a single access:
// bank b appears in lane b of read_data, with bank 0 in the LSBs.
// Memory contents are never reset, so each bank can map onto a block RAM.
module simple_bram #(
  parameter int unsigned PIXEL_BITS  = 8,
  parameter int unsigned IMAGE_WIDTH = 512,
  parameter int unsigned KERNEL_SIZE = 5,
  localparam int unsigned RB_COUNT   = KERNEL_SIZE - 1,
  localparam int unsigned WA_W       = $clog2(RB_COUNT * IMAGE_WIDTH),
  localparam int unsigned RA_W       = $clog2(IMAGE_WIDTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         kernel_size,
  input  logic                         we,
  input  logic [PIXEL_BITS-1:0]        write_data,
  input  logic [WA_W-1:0]              write_addr,
  input  logic                         re,
  input  logic [RA_W-1:0]              read_addr,
  output logic [PIXEL_BITS*RB_COUNT-1:0] read_data
);

  // One extra bit so the per-bank offset wraps to a large value when write_addr is below a
  // bank's base address, which the range check then rejects.
  localparam int unsigned OffW = WA_W + 1;

  // Column word fetched from each bank this cycle (already masked for range and mode).
  logic [PIXEL_BITS-1:0]          lane_word [RB_COUNT];
  logic [PIXEL_BITS*RB_COUNT-1:0] read_next;
  logic                           wr_allowed;

  // Reset level gates writes, so a write coinciding with an active reset is dropped while the
  // stored contents survive.
  assign wr_allowed = we & rst;

  for (genvar b = 0; b < RB_COUNT; b++) begin : g_bank
    localparam int unsigned Base = b * IMAGE_WIDTH;

    logic [PIXEL_BITS-1:0] mem [IMAGE_WIDTH];
    logic [OffW-1:0]       offset;
    logic                  hit;
    logic [RA_W-1:0]       col;
    logic                  bank_en;
    logic [PIXEL_BITS-1:0] raw_word;

    // Only banks 0 and 1 take part in 3x3 mode; the others are frozen and read as zero.
    if (b >= 2) begin : g_mode_gated
      assign bank_en = ~kernel_size;
    end else begin : g_always_on
      assign bank_en = 1'b1;
    end

    // Flat address decode without a divider: the bank owns [Base, Base + IMAGE_WIDTH).
    assign offset = {1'b0, write_addr} - OffW'(Base);
    assign hit    = offset < OffW'(IMAGE_WIDTH);
    assign col    = offset[RA_W-1:0];

    // Bank write port; plain clocked write with no reset keeps it BRAM-compatible.
    always_ff @(posedge clk) begin
      if (wr_allowed && hit && bank_en) begin
        mem[col] <= write_data;
      end
    end

    // Read address range check is only needed when the width is not a power of two.
    if ((1 << RA_W) == IMAGE_WIDTH) begin : g_full_range
      assign raw_word = mem[read_addr];
    end else begin : g_partial_range
      assign raw_word = (read_addr < RA_W'(IMAGE_WIDTH)) ? mem[read_addr] : '0;
    end

    assign lane_word[b] = bank_en ? raw_word : '0;
  end

  // Concatenate the bank words into the column vector, bank 0 in the LSBs.
  always_comb begin
    read_next = '0;
    for (int b = 0; b < RB_COUNT; b++) begin
      read_next[b*PIXEL_BITS +: PIXEL_BITS] = lane_word[b];
    end
  end

  // Output register: samples the old memory contents on a read edge, giving read-first
  // behaviour on a same-cycle write to the same location; holds when re is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      read_data <= '0;
    end else if (re) begin
      read_data <= read_next;
    end
  end

endmodule

// File: tb/tb_simple_bram.sv
// Self-checking bench for simple_bram: directed steps from the test plan followed by a random
// phase, all compared against an array-based model of the row buffers.
module tb_simple_bram;

  localparam int unsigned PB   = 8;
  localparam int unsigned IW   = 512;
  localparam int unsigned KS   = 5;
  localparam int unsigned RB   = KS - 1;
  localparam int unsigned AW   = $clog2(RB * IW);
  localparam int unsigned RAW  = $clog2(IW);
  localparam int unsigned DW   = PB * RB;

  logic          clk = 1'b0;
  logic          rst;
  logic          kernel_size;
  logic          we;
  logic [PB-1:0] write_data;
  logic [AW-1:0] write_addr;
  logic          re;
  logic [RAW-1:0] read_addr;
  logic [DW-1:0] read_data;

  int checks = 0;
  int errors = 0;

  logic [PB-1:0] model [RB][IW];
  logic [DW-1:0] exp_q;

  simple_bram #(
    .PIXEL_BITS (PB),
    .IMAGE_WIDTH(IW),
    .KERNEL_SIZE(KS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .kernel_size(kernel_size),
    .we         (we),
    .write_data (write_data),
    .write_addr (write_addr),
    .re         (re),
    .read_addr  (read_addr),
    .read_data  (read_data)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] column_of(int unsigned ra, bit ks);
    logic [DW-1:0] r;
    r = '0;
    for (int b = 0; b < RB; b++) begin
      if (!(ks && b >= 2) && ra < IW) r[b*PB +: PB] = model[b][ra];
    end
    return r;
  endfunction

  task automatic check(string tag, logic [DW-1:0] expv);
    checks++;
    assert (read_data === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, read_data, expv);
    end
  endtask

  task automatic drive(bit w, int unsigned wa, int unsigned wd, bit r, int unsigned ra);
    we         = w;
    write_addr = AW'(wa);
    write_data = PB'(wd);
    re         = r;
    read_addr  = RAW'(ra);
  endtask

  // Advance one clock edge, updating the model with read-first ordering, then compare.
  task automatic step(string tag);
    logic [DW-1:0] nxt;
    int unsigned   idx;
    int unsigned   col;
    nxt = exp_q;
    if (rst && re) nxt = column_of(read_addr, kernel_size);
    if (!rst) nxt = '0;
    if (rst && we) begin
      idx = write_addr / IW;
      col = write_addr % IW;
      if (idx < RB && !(kernel_size && idx >= 2)) model[idx][col] = write_data;
    end
    @(posedge clk);
    #1;
    exp_q = nxt;
    check(tag, exp_q);
  endtask

  initial begin
    rst         = 1'b1;
    kernel_size = 1'b0;
    drive(0, 0, 0, 0, 0);
    exp_q       = '0;

    // Reset asserted with activity toggling: output stays zero, writes are discarded.
    #2 rst = 1'b0;
    #1 check("reset_async", '0);
    for (int i = 0; i < 6; i++) begin
      drive(i % 2 == 0, $urandom_range(0, RB * IW - 1), $urandom_range(0, 255), 1,
            $urandom_range(0, IW - 1));
      step("reset_hold");
    end
    rst = 1'b1;

    // Fill every bank with addr mod 256.
    for (int a = 0; a < RB * IW; a++) begin
      drive(1, a, a % 256, 0, 0);
      step("fill_idle");
    end

    drive(0, 0, 0, 1, 0);   step("rd0");   check("rd0_const", 32'h00000000);
    drive(0, 0, 0, 1, 5);   step("rd5");   check("rd5_const", 32'h05050505);
    drive(0, 0, 0, 1, 100); step("rd100"); check("rd100_const", 32'h64646464);
    drive(0, 0, 0, 1, 511); step("rd511"); check("rd511_const", 32'hFFFFFFFF);

    // Lane ordering.
    drive(1, 7, 8'h11, 0, 0);    step("lane_w0");
    drive(1, 519, 8'h22, 0, 0);  step("lane_w1");
    drive(1, 1031, 8'h33, 0, 0); step("lane_w2");
    drive(1, 1543, 8'h44, 0, 0); step("lane_w3");
    drive(0, 0, 0, 1, 7);        step("lane_rd"); check("lane_const", 32'h44332211);

    // Read hold: address moves but re is low.
    drive(0, 0, 0, 0, 200);      step("hold");    check("hold_const", 32'h44332211);

    // Read-first on a colliding write.
    drive(1, 3, 8'hAA, 1, 3);    step("rf_old");  check("rf_old_const", 32'h03030303);
    drive(0, 0, 0, 1, 3);        step("rf_new");  check("rf_new_const", 32'h030303AA);

    // 3x3 mode: bank 2 write ignored, upper lanes read zero.
    kernel_size = 1'b1;
    drive(1, 1100, 8'h55, 0, 0); step("k3_wr");
    drive(0, 0, 0, 1, 76);       step("k3_rd");   check("k3_const", 32'h00004C4C);
    kernel_size = 1'b0;
    drive(0, 0, 0, 1, 76);       step("k5_rd");   check("k5_const", 32'h4C4C4C4C);

    // Back-to-back reads.
    drive(0, 0, 0, 1, 0);        step("b2b0");    check("b2b0_const", 32'h00000000);
    drive(0, 0, 0, 1, 1);        step("b2b1");    check("b2b1_const", 32'h01010101);
    drive(0, 0, 0, 1, 2);        step("b2b2");    check("b2b2_const", 32'h02020202);

    // Reset mid-operation: immediate clear, write on the reset edge dropped, memory kept.
    drive(1, 10, 8'hEE, 1, 10);
    rst = 1'b0;
    #1 exp_q = '0;
    check("midrst_async", '0);
    step("midrst_edge");
    #2 rst = 1'b1;
    drive(0, 0, 0, 1, 10);       step("midrst_rd"); check("midrst_const", 32'h0A0A0A0A);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      kernel_size = 1'($urandom_range(0, 1));
      drive($urandom_range(0, 1) == 1, $urandom_range(0, RB * IW - 1), $urandom_range(0, 255),
            $urandom_range(0, 3) != 0, $urandom_range(0, IW - 1));
      step("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
